// File: rtl/serial_link_phy_tx_sched.sv
// Credit-based round-robin TX scheduler with packet lock and flush handshake.
// Optional stall statistics counter enabled by SERIAL_LINK_TX_SCHED_STATS_EN.
`timescale 1ns/1ps

// state      | meaning
// ST_IDLE    | arbitrate among valid requesters; no beat forwarded
// ST_XFER    | granted requester streams beats to the PHY until its last beat
// ST_FLUSHED | flush requested and channel idle; no new packet starts
module serial_link_phy_tx_sched #(
    parameter int NumReq     = 4,
    parameter int DataWidth  = 16,
    parameter int NumCredits = 8,
    parameter int CntW       = $clog2(NumCredits + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [DataWidth-1:0]          phy_data_o,
    output logic                          phy_valid_o,
    input  logic                          phy_ready_i,
    input  logic                          credit_return_i,
    output logic [CntW-1:0]               credit_cnt_o,
    output logic                          credit_err_o,
    input  logic                          flush_i,
    output logic                          flushed_o,
`ifdef SERIAL_LINK_TX_SCHED_STATS_EN
    output logic [15:0]                   stall_cnt_o,
`endif
    output logic [NumReq-1:0]             grant_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NumReq);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
    localparam logic [CntW-1:0] MaxCred = CntW'(NumCredits);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_FLUSHED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] credits_q, credits_d;
    logic            credit_err_q, credit_err_set;

    logic [DataWidth-1:0] req_data_arr [NumReq];
    logic                 credit_avail;
    logic                 gnt_valid;
    logic                 gnt_last;
    logic                 fire;
    logic                 arb_any;
    logic [IdxW-1:0]      arb_idx;
    logic [IdxW:0]        arb_cand;

    for (genvar k = 0; k < NumReq; k++) begin : g_unpack
        assign req_data_arr[k] = req_data_i[k*DataWidth +: DataWidth];
    end

    assign credit_avail = (credits_q != '0);
    assign gnt_valid    = req_valid_i[gnt_q];
    assign gnt_last     = req_last_i[gnt_q];
    assign fire         = (state_q == ST_XFER) & gnt_valid & credit_avail & phy_ready_i;

    // First valid requester at or after rr_ptr, searched cyclically.
    always_comb begin
        arb_any  = 1'b0;
        arb_idx  = rr_ptr_q;
        arb_cand = '0;
        for (int i = 0; i < NumReq; i++) begin
            arb_cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
            if (arb_cand >= NumReqW) begin
                arb_cand = arb_cand - NumReqW;
            end
            if (!arb_any && req_valid_i[arb_cand[IdxW-1:0]]) begin
                arb_any = 1'b1;
                arb_idx = arb_cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        phy_valid_o = 1'b0;
        phy_data_o  = '0;
        req_ready_o = '0;
        grant_o     = '0;
        flushed_o   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSHED;
                end else if (arb_any && credit_avail) begin
                    gnt_d   = arb_idx;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                phy_data_o          = req_data_arr[gnt_q];
                phy_valid_o         = gnt_valid & credit_avail;
                req_ready_o[gnt_q]  = phy_ready_i & credit_avail;
                grant_o[gnt_q]      = 1'b1;
                // Flush is only honoured at a packet boundary.
                if (fire && gnt_last) begin
                    rr_ptr_d = (gnt_q == LastIdx) ? '0 : gnt_q + 1'b1;
                    state_d  = flush_i ? ST_FLUSHED : ST_IDLE;
                end
            end
            ST_FLUSHED: begin
                flushed_o = 1'b1;
                if (!flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        credits_d      = credits_q;
        credit_err_set = 1'b0;
        if (fire && !credit_return_i) begin
            credits_d = credits_q - 1'b1;
        end else if (credit_return_i && !fire) begin
            if (credits_q == MaxCred) begin
                credit_err_set = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            rr_ptr_q     <= '0;
            credits_q    <= MaxCred;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_ptr_q     <= rr_ptr_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_q | credit_err_set;
        end
    end

    assign credit_cnt_o = credits_q;
    assign credit_err_o = credit_err_q;

`ifdef SERIAL_LINK_TX_SCHED_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_XFER) && gnt_valid && !credit_avail
                     && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_serial_link_phy_tx_sched.sv
// Scoreboard bench for serial_link_phy_tx_sched: random traffic plus directed scenarios.
`timescale 1ns/1ps

module tb_serial_link_phy_tx_sched;

    localparam int NumReq     = 4;
    localparam int DataWidth  = 16;
    localparam int NumCredits = 8;
    localparam int CntW       = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b1;
    logic [NumReq-1:0]           req_valid_i = '0;
    logic [NumReq*DataWidth-1:0] req_data_i = '0;
    logic [NumReq-1:0]           req_last_i = '0;
    logic [NumReq-1:0]           req_ready_o;
    logic [DataWidth-1:0]        phy_data_o;
    logic                        phy_valid_o;
    logic                        phy_ready_i = 1'b0;
    logic                        credit_return_i = 1'b0;
    logic [CntW-1:0]             credit_cnt_o;
    logic                        credit_err_o;
    logic                        flush_i = 1'b0;
    logic                        flushed_o;
    logic [NumReq-1:0]           grant_o;
`ifdef SERIAL_LINK_TX_SCHED_STATS_EN
    logic [15:0]                 stall_cnt;
`endif

    serial_link_phy_tx_sched #(
        .NumReq(NumReq), .DataWidth(DataWidth), .NumCredits(NumCredits)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .phy_data_o(phy_data_o), .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i),
        .credit_return_i(credit_return_i), .credit_cnt_o(credit_cnt_o),
        .credit_err_o(credit_err_o),
        .flush_i(flush_i), .flushed_o(flushed_o),
`ifdef SERIAL_LINK_TX_SCHED_STATS_EN
        .stall_cnt_o(stall_cnt),
`endif
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    beat_t drv_q [NumReq][$];
    beat_t exp_q [NumReq][$];
    int    grant_log [$];

    int valid_pct   = 100;
    int ready_pct   = 100;
    int ret_pct     = 100;
    bit ret_en      = 1'b1;
    bit flush_rand  = 1'b0;
    bit flush_man   = 1'b0;
    bit manual_ret  = 1'b0;
    int outstanding = 0;
    int fire_total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NumReq-1:0] g);
        int r = -1;
        for (int i = 0; i < NumReq; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int k = 0; k < NumReq; k++) if (exp_q[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic push_pkt(input int k, input int len);
        for (int b = 0; b < len; b++) begin
            beat_t e;
            e.data = {4'(k), 12'($urandom)};
            e.last = (b == len - 1);
            drv_q[k].push_back(e);
            exp_q[k].push_back(e);
        end
    endtask

    // Requester / PHY / credit-return driver.
    logic [NumReq-1:0] acc;
    logic              fired;
    initial begin : driver
        forever begin
            @(negedge clk_i);
            acc   = rst_i ? '0 : (req_valid_i & req_ready_o);
            fired = !rst_i && phy_valid_o && phy_ready_i;
            @(posedge clk_i);
            #1;
            if (fired) begin
                outstanding++;
                fire_total++;
            end
            for (int k = 0; k < NumReq; k++) begin
                if (acc[k] && drv_q[k].size() > 0) void'(drv_q[k].pop_front());
            end
            for (int k = 0; k < NumReq; k++) begin
                if (drv_q[k].size() > 0) begin
                    req_valid_i[k] = ($urandom_range(1, 100) <= valid_pct);
                    req_data_i[k*DataWidth +: DataWidth] = drv_q[k][0].data;
                    req_last_i[k] = drv_q[k][0].last;
                end else begin
                    req_valid_i[k] = 1'b0;
                    req_data_i[k*DataWidth +: DataWidth] = '0;
                    req_last_i[k] = 1'b0;
                end
            end
            phy_ready_i = ($urandom_range(1, 100) <= ready_pct);
            credit_return_i = 1'b0;
            if (!rst_i) begin
                if (manual_ret) begin
                    credit_return_i = 1'b1;
                    manual_ret = 1'b0;
                    if (outstanding > 0) outstanding--;
                end else if (ret_en && outstanding > 0 && $urandom_range(1, 100) <= ret_pct) begin
                    credit_return_i = 1'b1;
                    outstanding--;
                end
            end
            if (flush_rand) begin
                if (flush_i) flush_i = ($urandom_range(1, 100) > 30);
                else         flush_i = ($urandom_range(1, 100) <= 4);
            end else begin
                flush_i = flush_man;
            end
        end
    end

    // Reference model (0 idle, 1 transferring, 2 flushed) and scoreboard monitor.
    int               m_st, m_owner, m_rr, m_cred, c;
    bit               m_err, m_fire, found;
    logic [NumReq-1:0] exp_grant, prev_grant;
    beat_t            e_beat;
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                m_st = 0; m_owner = 0; m_rr = 0; m_cred = NumCredits; m_err = 1'b0;
                prev_grant = '0;
            end else begin
                if (grant_o != '0 && prev_grant == '0) grant_log.push_back(onehot_idx(grant_o));
                prev_grant = grant_o;
                exp_grant = (m_st == 1) ? NumReq'(1 << m_owner) : '0;
                chk("grant", grant_o, exp_grant);
                chk("flushed", flushed_o, m_st == 2);
                chk("credit_cnt", credit_cnt_o, m_cred);
                chk("credit_err", credit_err_o, m_err);
                m_fire = 1'b0;
                if (m_st == 1) begin
                    m_fire = req_valid_i[m_owner] && (m_cred > 0) && phy_ready_i;
                    chk("phy_valid", phy_valid_o, req_valid_i[m_owner] && (m_cred > 0));
                    chk("req_ready", req_ready_o,
                        (phy_ready_i && m_cred > 0) ? NumReq'(1 << m_owner) : '0);
                    if (m_fire) begin
                        if (exp_q[m_owner].size() == 0) begin
                            n_checks++; n_errors++;
                            $display("FAIL beat_order: got beat from req %0d, expected none pending", m_owner);
                        end else begin
                            e_beat = exp_q[m_owner].pop_front();
                            chk("phy_data", phy_data_o, e_beat.data);
                            if (e_beat.last) begin
                                m_rr = (m_owner + 1) % NumReq;
                                m_st = flush_i ? 2 : 0;
                            end
                        end
                    end
                end else begin
                    chk("idle_phy_valid", phy_valid_o, 0);
                    chk("idle_phy_data", phy_data_o, 0);
                    chk("idle_req_ready", req_ready_o, 0);
                    if (m_st == 0) begin
                        if (flush_i) begin
                            m_st = 2;
                        end else if (req_valid_i != '0 && m_cred > 0) begin
                            found = 1'b0;
                            for (int j = 0; j < NumReq; j++) begin
                                c = (m_rr + j) % NumReq;
                                if (!found && req_valid_i[c]) begin
                                    found = 1'b1;
                                    m_owner = c;
                                end
                            end
                            m_st = 1;
                        end
                    end else if (!flush_i) begin
                        m_st = 0;
                    end
                end
                if (m_fire && !credit_return_i) m_cred--;
                else if (credit_return_i && !m_fire) begin
                    if (m_cred == NumCredits) m_err = 1'b1;
                    else m_cred++;
                end
            end
        end
    end

    task automatic assert_rst();
        rst_i = 1'b1;
        for (int k = 0; k < NumReq; k++) begin
            drv_q[k].delete();
            exp_q[k].delete();
        end
        outstanding = 0;
        flush_man   = 1'b0;
        manual_ret  = 1'b0;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic reset_dut();
        @(posedge clk_i);
        #3;
        assert_rst();
        release_rst();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(all_empty() && outstanding == 0) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL %s: got timeout after %0d cycles, expected traffic drained", name, n);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic wait_credit(input int value, input int budget, input string name);
        int n = 0;
        while (credit_cnt_o != CntW'(value) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, credit_cnt_o, value);
    endtask

    int base;
    initial begin : main
        repeat (3) @(negedge clk_i);
        chk("rst_grant", grant_o, 0);
        chk("rst_phy_valid", phy_valid_o, 0);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_credit_cnt", credit_cnt_o, NumCredits);
        chk("rst_credit_err", credit_err_o, 0);
        chk("rst_flushed", flushed_o, 0);
        chk("rst_phy_data", phy_data_o, 0);
        #2 rst_i = 1'b0;
        @(negedge clk_i);

        // Random traffic with random flushes and credit returns.
        valid_pct = 80; ready_pct = 75; ret_pct = 60; ret_en = 1'b1; flush_rand = 1'b1;
        for (int k = 0; k < NumReq; k++)
            for (int p = 0; p < 25; p++) push_pkt(k, $urandom_range(1, 4));
        wait_drain(8000, "random_drain");
        flush_rand = 1'b0;
        repeat (4) @(negedge clk_i);

        // Fairness: single-beat packets from all requesters.
        reset_dut();
        valid_pct = 100; ready_pct = 100; ret_pct = 100; ret_en = 1'b1;
        grant_log.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NumReq; k++) push_pkt(k, 1);
        wait_drain(200, "fair_drain");
        chk("fair_count", grant_log.size(), 8);
        if (grant_log.size() >= 8)
            for (int i = 0; i < 8; i++) chk($sformatf("fair_grant%0d", i), grant_log[i], i % NumReq);

        // Packet lock: 3-beat packet on req0 while req1 waits.
        grant_log.delete();
        push_pkt(0, 3);
        push_pkt(1, 1);
        wait_drain(200, "lock_drain");
        chk("lock_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            chk("lock_first", grant_log[0], 0);
            chk("lock_second", grant_log[1], 1);
        end

        // Credit exhaustion, single-return resume, then overflow error.
        reset_dut();
        ret_en = 1'b0;
        base = fire_total;
        push_pkt(0, 12);
        wait_credit(0, 40, "exh_reach_zero");
        repeat (3) @(negedge clk_i);
        chk("exh_fires", fire_total - base, 8);
        chk("exh_phy_valid", phy_valid_o, 0);
        chk("exh_grant_held", grant_o, 4'b0001);
        manual_ret = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("exh_one_more", fire_total - base, 9);
        chk("exh_credit_zero", credit_cnt_o, 0);
        ret_en = 1'b1;
        wait_drain(200, "exh_drain");
        chk("exh_credit_full", credit_cnt_o, NumCredits);
        ret_en = 1'b0;
        manual_ret = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("err_sticky", credit_err_o, 1);
        chk("err_saturate", credit_cnt_o, NumCredits);

        // Flush requested mid-packet.
        reset_dut();
        chk("err_cleared", credit_err_o, 0);
        ret_en = 1'b1;
        base = fire_total;
        push_pkt(0, 4);
        for (int n = 0; n < 20 && (fire_total - base) < 2; n++) @(negedge clk_i);
        chk("flush_two_beats", (fire_total - base) >= 2, 1);
        flush_man = 1'b1;
        push_pkt(1, 1);
        push_pkt(2, 1);
        grant_log.delete();
        for (int n = 0; n < 20 && !flushed_o; n++) @(negedge clk_i);
        chk("flush_reached", flushed_o, 1);
        chk("flush_pkt_done", exp_q[0].size(), 0);
        repeat (5) @(negedge clk_i);
        chk("flush_hold", flushed_o, 1);
        chk("flush_no_grant", grant_o, 0);
        chk("flush_pending", exp_q[1].size(), 1);
        flush_man = 1'b0;
        wait_drain(200, "flush_drain");
        chk("flush_resume_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            chk("flush_resume_first", grant_log[0], 1);
            chk("flush_resume_second", grant_log[1], 2);
        end

        // Asynchronous reset during a transfer.
        reset_dut();
        ret_en = 1'b0;
        push_pkt(0, 6);
        wait_credit(5, 40, "areset_credit5");
        chk("areset_pre_grant", grant_o, 4'b0001);
        @(posedge clk_i);
        #3;
        assert_rst();
        #1;
        chk("areset_phy_valid", phy_valid_o, 0);
        chk("areset_req_ready", req_ready_o, 0);
        chk("areset_grant", grant_o, 0);
        chk("areset_credit", credit_cnt_o, NumCredits);
        chk("areset_flushed", flushed_o, 0);
        chk("areset_phy_data", phy_data_o, 0);
        release_rst();
        chk("areset_after", credit_cnt_o, NumCredits);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before t=900000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_link_phy_tx_sched.md
Name: serial_link_phy_tx_sched

Overview:
- Credit-based transmit scheduler in front of one physical-layer TX channel.
- Shares that channel between NumReq packet sources using round-robin arbitration with packet lock: a grant is held until the `last` beat.
- Sends a beat only while a receiver credit is available, so the remote RX CDC FIFO (depth NumCredits) can never overflow.
- Provides a flush handshake, used by the link-layer controller before clock-divider reconfiguration.

Parameters:
- NumReq, 4, number of requesters (≥2).
- DataWidth, 16, beat width; equals NumLanes*2 of the PHY channel.
- NumCredits, 8, receiver FIFO depth; initial and maximum credit count.
- CntW, $clog2(NumCredits+1), width of the credit counter (derived).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NumReq  per-requester beat valid.
- req_data_i  in  NumReq*DataWidth  per-requester beat; requester k occupies [k*DataWidth +: DataWidth].
- req_last_i  in  NumReq  marks final beat of a packet.
- req_ready_o  out  NumReq  per-requester beat accepted.
- phy_data_o  out  DataWidth  beat to PHY TX.
- phy_valid_o  out  1  beat valid to PHY TX.
- phy_ready_i  in  1  PHY TX accepts beat.
- credit_return_i  in  1  one-cycle pulse; returns one credit.
- credit_cnt_o  out  CntW  current credit count.
- credit_err_o  out  1  sticky; credit returned while count == NumCredits.
- flush_i  in  1  level; stop starting new packets.
- flushed_o  out  1  idle and flush_i high.
- grant_o  out  NumReq  one-hot owner in XFER, else 0.

Behaviour:
- Reset values: state IDLE, rr_ptr = 0, credits = NumCredits, credit_err_o = 0. All outputs take reset-consistent values: phy_valid_o = 0, req_ready_o = 0, grant_o = 0, flushed_o = 0.
- FSM state IDLE:
  - If flush_i = 1, go to FLUSHED.
  - Else if any req_valid_i and credits > 0: choose the first valid index at or after rr_ptr (cyclic), register it as gnt, go to XFER.
  - Arbitration latency is 1 cycle; no beat is forwarded in IDLE.
- FSM state XFER:
  - phy_data_o = req_data_i[gnt].
  - phy_valid_o = req_valid_i[gnt] & (credits > 0).
  - req_ready_o[gnt] = phy_ready_i & (credits > 0); all other bits 0.
  - Beat fires when phy_valid_o & phy_ready_i.
  - Fire with req_last_i[gnt]: rr_ptr = (gnt+1) mod NumReq. Next state is FLUSHED if flush_i, else IDLE.
  - flush_i never truncates a packet.
- FSM state FLUSHED:
  - flushed_o = 1.
  - Return to IDLE when flush_i = 0.
- Combinational path: valid, ready and data pass combinationally between requester and PHY in XFER; there are no data registers.
- Credit counter, next value:
  - fire & !credit_return_i: credits − 1.
  - credit_return_i & !fire: credits + 1.
  - Both in the same cycle: unchanged.
  - Return while credits == NumCredits and no fire: credits saturate at NumCredits and credit_err_o is set (cleared only by reset).
  - Credits never underflow; fire requires credits > 0.
- Credits reaching 0 mid-packet: hold XFER with phy_valid_o = 0; resume on the cycle after a return.
- Requester rule: req_valid_i[gnt] may drop mid-packet; the scheduler waits in XFER.
- Unused phy_data_o outside XFER: drive 0.
- Reset asserted mid-packet: return to reset values immediately (asynchronous); the partial packet is lost and upper layers handle it.

Optional Feature:
- Macro: SERIAL_LINK_TX_SCHED_STATS_EN.
- Defined: adds output stall_cnt_o [15:0], a saturating count of cycles in XFER with req_valid_i[gnt] = 1 and credits == 0. Reset 0; holds at 16'hFFFF.
- Undefined: the port and counter are absent.

Test Plan:
- Fairness: all 4 requesters hold valid and send 1-beat packets, phy_ready_i = 1, credits returned each cycle → grants in order 0,1,2,3,0. Each grant preceded by 1 IDLE cycle.
- Packet lock: req0 sends 3-beat packet while req1 is valid → grant_o = 4'b0001 for all 3 beats. Then req1 granted; no interleaving on phy_data_o.
- Credit exhaustion: NumCredits = 8, no returns, req0 sends 12-beat packet → 8 beats fire, then phy_valid_o = 0 and credit_cnt_o = 0. A return pulse lets exactly 1 more beat fire.
- Simultaneous fire + return with credits = 3 → credit_cnt_o stays 3. A return at 8 with no fire → stays 8, credit_err_o = 1.
- Flush mid-packet: flush_i raised on beat 2 of 4 → beats 3–4 complete, then FLUSHED with flushed_o = 1 and no new grant despite valids. flush_i low → IDLE, arbitration resumes from rr_ptr.
- Async reset during XFER with credits = 5 → outputs go to reset values immediately and credit_cnt_o = 8.
